// File: rtl/craps_sequencer_if.sv
// Roll/dice inputs and latched game-state outputs of craps_sequencer.
interface craps_sequencer_if;
  logic       roll;
  logic [2:0] die_a;
  logic [2:0] die_b;
  logic [2:0] die_a_q;
  logic [2:0] die_b_q;
  logic [3:0] point;
  logic       win;
  logic       loss;
  logic [3:0] win_count;
  logic [3:0] loss_count;
  logic       roll_err;

  modport master (
    output roll, die_a, die_b,
    input  die_a_q, die_b_q, point, win, loss, win_count, loss_count, roll_err
  );

  modport slave (
    input  roll, die_a, die_b,
    output die_a_q, die_b_q, point, win, loss, win_count, loss_count, roll_err
  );
endinterface

// File: rtl/craps_sequencer.sv
// Craps round sequencer: synchronised roll button, dice latch, IDLE/POINT/WIN/LOSE FSM.
// Define CRAPS_DEBOUNCE_EN to add a DB_CYCLES-cycle debounce filter on the roll level.
module craps_sequencer #(
  parameter logic [15:0] DB_CYCLES = 16'd50000
) (
  input logic             clock,
  input logic             reset,
  craps_sequencer_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StPoint, StWin, StLose} state_e;

  state_e     state_q;
  logic       sync1_q, sync2_q;
  logic       level;
  logic       prev_q;
  logic [1:0] fill_q;
  logic       armed_q;
  logic       roll_event;
  logic [3:0] sum;
  logic       dice_ok;

  logic [2:0] latched_a_q, latched_b_q;
  logic [3:0] point_q;
  logic       win_q, loss_q;
  logic [3:0] win_count_q, loss_count_q;
  logic       roll_err_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= bus.roll;
      sync2_q <= sync1_q;
    end
  end

`ifdef CRAPS_DEBOUNCE_EN
  logic        db_level_q;
  logic [15:0] db_cnt_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      db_level_q <= 1'b0;
      db_cnt_q   <= 16'd0;
    end else if (sync2_q != db_level_q) begin
      if (db_cnt_q + 16'd1 >= DB_CYCLES) begin
        db_level_q <= sync2_q;
        db_cnt_q   <= 16'd0;
      end else begin
        db_cnt_q <= db_cnt_q + 16'd1;
      end
    end else begin
      db_cnt_q <= 16'd0;
    end
  end

  assign level = db_level_q;
`else
  logic unused_db_cycles;
  assign unused_db_cycles = ^DB_CYCLES;
  assign level = sync2_q;
`endif

  // The synchroniser reads low for two cycles after reset whatever the pin does, so only
  // arm the edge detector once a genuinely released button has been seen.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fill_q  <= 2'd0;
      armed_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      if (fill_q != 2'd2) begin
        fill_q <= fill_q + 2'd1;
      end
      if (fill_q == 2'd2 && !sync2_q && !level) begin
        armed_q <= 1'b1;
      end
      prev_q <= level;
    end
  end

  assign roll_event = level & ~prev_q & armed_q;
  assign sum        = {1'b0, bus.die_a} + {1'b0, bus.die_b};
  assign dice_ok    = (bus.die_a != 3'd0) && (bus.die_a != 3'd7) &&
                      (bus.die_b != 3'd0) && (bus.die_b != 3'd7);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      latched_a_q  <= 3'd7;
      latched_b_q  <= 3'd7;
      point_q      <= 4'd0;
      win_q        <= 1'b0;
      loss_q       <= 1'b0;
      win_count_q  <= 4'd0;
      loss_count_q <= 4'd0;
      roll_err_q   <= 1'b0;
    end else begin
      roll_err_q <= 1'b0;
      if (roll_event) begin
        if (!dice_ok) begin
          roll_err_q <= 1'b1;
        end else begin
          latched_a_q <= bus.die_a;
          latched_b_q <= bus.die_b;
          unique case (state_q)
            StPoint: begin
              if (sum == point_q) begin
                state_q     <= StWin;
                win_q       <= 1'b1;
                loss_q      <= 1'b0;
                win_count_q <= win_count_q + 4'd1;
              end else if (sum == 4'd7) begin
                state_q      <= StLose;
                win_q        <= 1'b0;
                loss_q       <= 1'b1;
                loss_count_q <= loss_count_q + 4'd1;
              end
            end
            default: begin
              point_q <= 4'd0;
              case (sum)
                4'd7, 4'd11: begin
                  state_q     <= StWin;
                  win_q       <= 1'b1;
                  loss_q      <= 1'b0;
                  win_count_q <= win_count_q + 4'd1;
                end
                4'd2, 4'd3, 4'd12: begin
                  state_q      <= StLose;
                  win_q        <= 1'b0;
                  loss_q       <= 1'b1;
                  loss_count_q <= loss_count_q + 4'd1;
                end
                default: begin
                  state_q <= StPoint;
                  point_q <= sum;
                  win_q   <= 1'b0;
                  loss_q  <= 1'b0;
                end
              endcase
            end
          endcase
        end
      end
    end
  end

  assign bus.die_a_q    = latched_a_q;
  assign bus.die_b_q    = latched_b_q;
  assign bus.point      = point_q;
  assign bus.win        = win_q;
  assign bus.loss       = loss_q;
  assign bus.win_count  = win_count_q;
  assign bus.loss_count = loss_count_q;
  assign bus.roll_err   = roll_err_q;

  a_win_loss_exclusive: assert property (@(posedge clock) disable iff (!reset)
    !(win_q && loss_q));
  a_flags_match_state: assert property (@(posedge clock) disable iff (!reset)
    (win_q == (state_q == StWin)) && (loss_q == (state_q == StLose)));

endmodule

// File: doc/craps_sequencer.md
CRAPS_SEQUENCER -- requirements
Module: craps_sequencer

Interface
REQ-001 The block SHALL have parameter DB_CYCLES, default 16'd50000, meaning the roll-input debounce stability window in clock cycles (used only with CRAPS_DEBOUNCE_EN).
REQ-002 The block SHALL use one clock and SHALL have an asynchronous, active-low reset.
REQ-003 The ports SHALL be:
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous active-low reset
- roll  in  1  raw roll pushbutton, active-high, asynchronous to clock
- die_a  in  3  free-running die counter A, valid values 1..6
- die_b  in  3  free-running die counter B, valid values 1..6
- die_a_q  out  3  latched die A, 7 = blank
- die_b_q  out  3  latched die B, 7 = blank
- point  out  4  current point, 0 = no point
- win  out  1  round won
- loss  out  1  round lost
- win_count  out  4  rounds won
- loss_count  out  4  rounds lost
- roll_err  out  1  one-cycle pulse: invalid dice on a roll event

Function
REQ-004 roll SHALL pass through a 2-flop synchronizer; a roll event SHALL be a single-cycle pulse on the rising edge of the synchronized (or debounced) level.
REQ-005 Holding roll high SHALL produce exactly one roll event.
REQ-006 Without debounce, if roll is first sampled high at edge k, all outputs SHALL reflect the result after edge k+2.
REQ-007 The FSM SHALL have states IDLE, POINT, WIN and LOSE; all outputs SHALL be registered.
REQ-008 On a roll event, die_a and die_b SHALL be latched into die_a_q and die_b_q, and sum = die_a + die_b SHALL be computed at 4 bits (range 2..12).
REQ-009 A roll event in IDLE, WIN or LOSE SHALL be a come-out roll that clears point:
- sum 7 or 11 -> WIN
- sum 2, 3 or 12 -> LOSE
- any other sum -> POINT, with point = sum
REQ-010 A roll event in POINT SHALL resolve as follows:
- sum == point -> WIN
- sum == 7 -> LOSE
- otherwise stay in POINT, with point unchanged and dice updated
REQ-011 win SHALL be 1 only in WIN and loss SHALL be 1 only in LOSE; they SHALL never be 1 together.
REQ-012 point SHALL hold its value in WIN and LOSE until the next come-out roll.
REQ-013 win_count and loss_count SHALL increment by 1 on each entry to WIN and LOSE respectively, wrapping 15 -> 0.
REQ-014 If die_a or die_b is 0 or 7 at a roll event, the event SHALL be discarded (state, dice and point unchanged) and roll_err SHALL pulse high for one cycle.

Reset
REQ-015 While reset is low, the block SHALL set: state IDLE; die_a_q = die_b_q = 7; point = 0; win = loss = 0; win_count = loss_count = 0; roll_err = 0; synchronizer and debounce state cleared.
REQ-016 Reset asserted mid-round SHALL take effect immediately (asynchronously); a roll held high through reset release SHALL NOT generate an event until roll is released and pressed again.

Configuration
REQ-017 With macro CRAPS_DEBOUNCE_EN defined, the synchronized roll level SHALL change only after it has differed from the current debounced level for DB_CYCLES consecutive cycles, adding DB_CYCLES cycles of latency to REQ-006.
REQ-018 Without CRAPS_DEBOUNCE_EN, the synchronized level SHALL feed the edge detector directly, and DB_CYCLES SHALL be unused.

Verification
REQ-019 Reset, then dice 3+4, press roll -> win=1, point=0, win_count=1, die_a_q=3, die_b_q=4, results after edge k+2.
REQ-020 Reset, dice 1+1, press -> loss=1, loss_count=1; next press with dice 5+6 -> win=1, loss=0, win_count=1.
REQ-021 Dice 2+4 -> POINT, point=6; dice 3+5 -> POINT, point=6; dice 1+5 -> WIN; repeat the sequence with dice 3+4 on the last roll -> LOSE.
REQ-022 Roll held high for 100 cycles -> exactly one event; dice 0+3 on a press -> roll_err pulses once, all other outputs unchanged.
REQ-023 Reset asserted while in POINT with roll held high -> immediate IDLE and blank dice; no event after release until roll falls and rises again; 16 wins -> win_count wraps to 0.
REQ-024 With CRAPS_DEBOUNCE_EN and DB_CYCLES=8, a bouncing press (pulses shorter than 8 cycles) followed by a stable high -> exactly one event, 8 cycles later than REQ-006.
